// File: rtl/muon_daq_pkg.sv
// Shared definitions for the muon DAQ blocks: default counter width and
// the gate-window FSM encoding.
package muon_daq_pkg;

  localparam int COUNT_WIDTH_DEFAULT = 32;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    COUNTING  = 1'b1
  } gate_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clk_in domain through a flop chain
// and emits a one-cycle strobe on each rising edge of the synchronized level.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic aresetn,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_in or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/gate_rate_counter.sv
// Counts detector pulses between consecutive gate rising edges and hands each
// window's total downstream over a valid/ready port with overrun reporting.
module gate_rate_counter
  import muon_daq_pkg::*;
#(
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_in,
  input  logic                   aresetn,
  input  logic                   gate_in,
  input  logic                   pulse_in,
  input  logic                   en,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [COUNT_WIDTH-1:0] m_count,
  output logic                   m_saturated,
  output logic                   m_overrun,
  output logic                   window_active
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic                   gate_rise;
  logic                   pulse_rise;
  gate_state_t            state_q;
  gate_state_t            state_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   sat_q;
  logic                   lost_q;
  logic                   close;
  logic                   load;
  logic [COUNT_WIDTH-1:0] result;
  logic                   result_sat;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_gate_sync (
    .clk_in   (clk_in),
    .aresetn  (aresetn),
    .async_in (gate_in),
    .rise     (gate_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk_in   (clk_in),
    .aresetn  (aresetn),
    .async_in (pulse_in),
    .rise     (pulse_rise)
  );

  always_ff @(posedge clk_in or negedge aresetn) begin
    if (!aresetn) state_q <= WAIT_SYNC;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SYNC: if (gate_rise && en) state_d = COUNTING;
      COUNTING:  if (!en)             state_d = WAIT_SYNC;
      default:                        state_d = WAIT_SYNC;
    endcase
  end

  assign window_active = (state_q == COUNTING);
  assign close         = window_active && en && gate_rise;
  assign load          = close && (!m_valid || m_ready);

  // A pulse arriving with the closing gate edge belongs to the closing window.
  always_comb begin
    result     = count_q;
    result_sat = sat_q;
    if (pulse_rise) begin
      if (count_q == COUNT_MAX) result_sat = 1'b1;
      else                      result     = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or negedge aresetn) begin
    if (!aresetn) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (!window_active || !en || gate_rise) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (pulse_rise) begin
      if (count_q == COUNT_MAX) sat_q   <= 1'b1;
      else                      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  // Results that cannot be loaded are dropped and flagged on the next one.
  always_ff @(posedge clk_in or negedge aresetn) begin
    if (!aresetn) begin
      m_valid     <= 1'b0;
      m_count     <= '0;
      m_saturated <= 1'b0;
      m_overrun   <= 1'b0;
      lost_q      <= 1'b0;
    end else if (load) begin
      m_valid     <= 1'b1;
      m_count     <= result;
      m_saturated <= result_sat;
      m_overrun   <= lost_q;
      lost_q      <= 1'b0;
    end else begin
      if (close)               lost_q  <= 1'b1;
      if (m_valid && m_ready)  m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gate_rate_counter.sv
// Directed bench for gate_rate_counter: a 32-bit and a 4-bit instance share
// stimulus; accepted results are captured into queues and compared.
module tb_gate_rate_counter;

  logic        clk_in = 1'b0;
  logic        aresetn = 1'b0;
  logic        gate_in = 1'b0;
  logic        pulse_in = 1'b0;
  logic        en = 1'b0;
  logic        m_ready = 1'b1;

  logic        w_valid, w_sat, w_ovr, w_active;
  logic [31:0] w_count;
  logic        n_valid, n_sat, n_ovr, n_active;
  logic [3:0]  n_count;

  typedef struct {
    logic [31:0] count;
    logic        sat;
    logic        ovr;
  } res_t;

  typedef struct {
    int          len;
    int          pulses;
    logic [31:0] exp_w;
    logic [31:0] exp_n;
    logic        exp_n_sat;
  } vec_t;

  res_t wide_q[$];
  res_t narrow_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk_in = ~clk_in;

  gate_rate_counter #(.COUNT_WIDTH(32), .SYNC_STAGES(2)) dut_wide (
    .clk_in(clk_in), .aresetn(aresetn), .gate_in(gate_in), .pulse_in(pulse_in),
    .en(en), .m_ready(m_ready), .m_valid(w_valid), .m_count(w_count),
    .m_saturated(w_sat), .m_overrun(w_ovr), .window_active(w_active)
  );

  gate_rate_counter #(.COUNT_WIDTH(4), .SYNC_STAGES(2)) dut_narrow (
    .clk_in(clk_in), .aresetn(aresetn), .gate_in(gate_in), .pulse_in(pulse_in),
    .en(en), .m_ready(m_ready), .m_valid(n_valid), .m_count(n_count),
    .m_saturated(n_sat), .m_overrun(n_ovr), .window_active(n_active)
  );

  // Every handshake is logged so checks see each accepted result exactly once.
  always @(negedge clk_in) begin
    if (aresetn && w_valid && m_ready) wide_q.push_back('{w_count, w_sat, w_ovr});
    if (aresetn && n_valid && m_ready) narrow_q.push_back('{{28'd0, n_count}, n_sat, n_ovr});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      pulse_in = 1'b1;
      tick(2);
      pulse_in = 1'b0;
      tick(2);
    end
  endtask

  task automatic gate_pulse();
    gate_in = 1'b1;
    tick(4);
    gate_in = 1'b0;
  endtask

  // Pulses, idle fill, then the gate edge that ends the current window.
  task automatic close_window(input int n, input int len);
    pulses(n);
    tick(len - 4 * n - 4);
    gate_pulse();
  endtask

  task automatic get_result(input string name, input bit narrow, output res_t r);
    int waited = 0;
    while (((narrow ? narrow_q.size() : wide_q.size()) == 0) && waited < 40) begin
      @(negedge clk_in);
      waited++;
    end
    r = '{32'hFFFF_FFFF, 1'b1, 1'b1};
    if (narrow && narrow_q.size() > 0)      r = narrow_q.pop_front();
    else if (!narrow && wide_q.size() > 0)  r = wide_q.pop_front();
    else begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got no result expected one within 40 cycles", name);
    end
  endtask

  task automatic expect_result(input string name, input bit narrow, input logic [31:0] cnt,
                               input logic sat, input logic ovr);
    res_t r;
    get_result(name, narrow, r);
    check_output({name, ".count"}, r.count, cnt);
    check_output({name, ".sat"}, {31'd0, r.sat}, {31'd0, sat});
    check_output({name, ".ovr"}, {31'd0, r.ovr}, {31'd0, ovr});
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    tick(3);
    aresetn = 1'b1;
    tick(2);
  endtask

  initial begin
    vec_t vecs[9];
    vecs[0] = '{1000, 37, 32'd37, 32'd15, 1'b1};
    vecs[1] = '{1000, 37, 32'd37, 32'd15, 1'b1};
    vecs[2] = '{1000, 37, 32'd37, 32'd15, 1'b1};
    vecs[3] = '{200,  0,  32'd0,  32'd0,  1'b0};
    vecs[4] = '{200,  1,  32'd1,  32'd1,  1'b0};
    vecs[5] = '{200,  20, 32'd20, 32'd15, 1'b1};
    vecs[6] = '{200,  3,  32'd3,  32'd3,  1'b0};
    vecs[7] = '{200,  15, 32'd15, 32'd15, 1'b0};
    vecs[8] = '{200,  16, 32'd16, 32'd15, 1'b1};

    // Reset values
    tick(2);
    check_output("reset.m_valid", {31'd0, w_valid}, 32'd0);
    check_output("reset.m_count", w_count, 32'd0);
    check_output("reset.window_active", {31'd0, w_active}, 32'd0);
    aresetn = 1'b1;
    en = 1'b1;
    tick(2);

    // Start-up: pulses before the first gate edge are ignored
    pulses(5);
    check_output("startup.wait_active", {31'd0, w_active}, 32'd0);
    gate_pulse();
    tick(4);
    check_output("startup.open_no_result", wide_q.size(), 32'd0);
    check_output("startup.active", {31'd0, w_active}, 32'd1);
    close_window(10, 100);
    expect_result("startup", 1'b0, 32'd10, 1'b0, 1'b0);
    narrow_q.delete();

    // Table: each record closes the window opened by the previous gate edge
    for (int i = 0; i < 9; i++) begin
      close_window(vecs[i].pulses, vecs[i].len);
      expect_result($sformatf("vec%0d.wide", i), 1'b0, vecs[i].exp_w, 1'b0, 1'b0);
      expect_result($sformatf("vec%0d.narrow", i), 1'b1, vecs[i].exp_n, vecs[i].exp_n_sat, 1'b0);
    end

    // Coincident pulse and closing gate edge
    pulses(4);
    tick(10);
    gate_in = 1'b1;
    pulse_in = 1'b1;
    tick(2);
    pulse_in = 1'b0;
    tick(2);
    gate_in = 1'b0;
    expect_result("coincide.close", 1'b0, 32'd5, 1'b0, 1'b0);
    close_window(2, 60);
    expect_result("coincide.next", 1'b0, 32'd2, 1'b0, 1'b0);

    // Backpressure: first result held, two dropped, overrun on the next
    m_ready = 1'b0;
    close_window(4, 60);
    tick(4);
    check_output("bp.valid0", {31'd0, w_valid}, 32'd1);
    check_output("bp.count0", w_count, 32'd4);
    close_window(5, 60);
    close_window(6, 60);
    tick(4);
    check_output("bp.valid_held", {31'd0, w_valid}, 32'd1);
    check_output("bp.count_held", w_count, 32'd4);
    check_output("bp.ovr_held", {31'd0, w_ovr}, 32'd0);
    m_ready = 1'b1;
    expect_result("bp.first", 1'b0, 32'd4, 1'b0, 1'b0);
    tick(2);
    check_output("bp.valid_drop", {31'd0, w_valid}, 32'd0);
    close_window(7, 60);
    expect_result("bp.overrun", 1'b0, 32'd7, 1'b0, 1'b1);
    close_window(8, 60);
    expect_result("bp.after", 1'b0, 32'd8, 1'b0, 1'b0);
    narrow_q.delete();

    // Enable low abandons the window; gate edges then produce nothing
    en = 1'b0;
    tick(3);
    check_output("en.inactive", {31'd0, w_active}, 32'd0);
    close_window(3, 60);
    tick(10);
    check_output("en.no_result", wide_q.size(), 32'd0);
    en = 1'b1;
    tick(2);
    check_output("en.still_wait", {31'd0, w_active}, 32'd0);
    gate_pulse();
    tick(2);
    check_output("en.reopen", {31'd0, w_active}, 32'd1);
    close_window(2, 60);
    expect_result("en.result", 1'b0, 32'd2, 1'b0, 1'b0);

    // Reset mid-window: nothing emitted until a full fresh window ends
    pulses(8);
    aresetn = 1'b0;
    tick(1);
    check_output("rst.m_valid", {31'd0, w_valid}, 32'd0);
    check_output("rst.m_count", w_count, 32'd0);
    check_output("rst.active", {31'd0, w_active}, 32'd0);
    tick(2);
    aresetn = 1'b1;
    tick(10);
    check_output("rst.no_result", wide_q.size(), 32'd0);
    gate_pulse();
    tick(6);
    check_output("rst.first_gate_no_result", wide_q.size(), 32'd0);
    check_output("rst.first_gate_valid", {31'd0, w_valid}, 32'd0);
    close_window(3, 60);
    expect_result("rst.result", 1'b0, 32'd3, 1'b0, 1'b0);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
